// File: rtl/regfile_pkg.sv
// Shared defaults and read-bypass source selection for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WB_A  = 2'd1,
        SRC_WB_B  = 2'd2
    } byp_src_e;

    // Multiplier writeback outranks ALU writeback, which outranks stored data.
    function automatic byp_src_e byp_sel(input logic hit_a, input logic hit_b);
        if (hit_b) begin
            return SRC_WB_B;
        end
        if (hit_a) begin
            return SRC_WB_A;
        end
        return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination tracking for long-latency multiplier results,
// with a registered pending count and a sticky write-after-write error flag.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   busy_set,
    input  logic [ADDR_W-1:0]      busy_addr,
    input  logic                   we_a,
    input  logic [ADDR_W-1:0]      waddr_a,
    input  logic                   we_b,
    input  logic [ADDR_W-1:0]      waddr_b,
    output logic [2**ADDR_W-1:0]   pend,
    output logic [ADDR_W:0]        pend_cnt,
    output logic                   waw_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             waw_q, waw_d;
    logic             set_v, clr_v, inc_v;

    always_comb begin
        set_v  = busy_set && (busy_addr != '0);
        // A fresh issue to the same register keeps the bit, so the completion does not clear it.
        clr_v  = we_b && (waddr_b != '0) && pend_q[waddr_b]
                 && !(set_v && (busy_addr == waddr_b));
        inc_v  = set_v && !pend_q[busy_addr];
        pend_d = pend_q;
        if (clr_v) begin
            pend_d[waddr_b] = 1'b0;
        end
        if (set_v) begin
            pend_d[busy_addr] = 1'b1;
        end
        cnt_d = cnt_q + CW'(inc_v) - CW'(clr_v);
        waw_d = waw_q || (we_a && (waddr_a != '0) && pend_q[waddr_a]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
            waw_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            waw_q  <= waw_d;
        end
    end

    assign pend     = pend_q;
    assign pend_cnt = cnt_q;
    assign waw_err  = waw_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Two-write, multi-read register file with same-cycle write bypass and a
// scoreboard of registers awaiting multiplier writeback.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_a,
    input  logic [ADDR_W-1:0]        waddr_a,
    input  logic [DATA_W-1:0]        wdata_a,
    input  logic                     we_b,
    input  logic [ADDR_W-1:0]        waddr_b,
    input  logic [DATA_W-1:0]        wdata_b,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     waw_err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend;

    // Port B is applied last so it wins a same-address collision; register 0 stays zero.
    always_comb begin
        regs_d = regs_q;
        if (we_a && (waddr_a != '0)) begin
            regs_d[waddr_a] = wdata_a;
        end
        if (we_b && (waddr_b != '0)) begin
            regs_d[waddr_b] = wdata_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit_a, hit_b;
        logic [DATA_W-1:0] rd;

        assign ra    = raddr[p*ADDR_W +: ADDR_W];
        assign hit_a = we_a && (waddr_a == ra) && (ra != '0);
        assign hit_b = we_b && (waddr_b == ra) && (ra != '0);

        always_comb begin
            rd = regs_q[ra];
            case (byp_sel(hit_a, hit_b))
                SRC_WB_B: rd = wdata_b;
                SRC_WB_A: rd = wdata_a;
                default:  rd = regs_q[ra];
            endcase
        end

        assign rdata[p*DATA_W +: DATA_W] = rd;
        assign rpend[p] = pend[ra] && !(we_b && (waddr_b == ra));
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .we_a      (we_a),
        .waddr_a   (waddr_a),
        .we_b      (we_b),
        .waddr_b   (waddr_b),
        .pend      (pend),
        .pend_cnt  (pend_cnt),
        .waw_err   (waw_err)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and randomized checks of regfile_mp_sb against a behavioural model,
// with expectations queued at drive time and consumed when outputs are sampled.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_a, we_b, busy_set;
    logic [4:0]  waddr_a, waddr_b, busy_addr;
    logic [31:0] wdata_a, wdata_b;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rpend;
    logic [5:0]  pend_cnt;
    logic        waw_err;

    int checks = 0;
    int errors = 0;

    string       tq[$];
    logic [31:0] eq[$];

    logic [31:0] mregs [32];
    logic        mpend [32];
    logic        mwaw;

    regfile_mp_sb dut (
        .clk       (clk),
        .rst       (rst),
        .we_a      (we_a),
        .waddr_a   (waddr_a),
        .wdata_a   (wdata_a),
        .we_b      (we_b),
        .waddr_b   (waddr_b),
        .wdata_b   (wdata_b),
        .raddr     (raddr),
        .rdata     (rdata),
        .rpend     (rpend),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .pend_cnt  (pend_cnt),
        .waw_err   (waw_err)
    );

    always #5 clk = ~clk;

    task automatic push(input string t, input logic [31:0] e);
        tq.push_back(t);
        eq.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (eq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            t = tq.pop_front();
            e = eq.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'(i);
            mpend[i] = 1'b0;
        end
        mwaw = 1'b0;
    endtask

    function automatic int mcnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mpend[i]);
        return n;
    endfunction

    task automatic model_update();
        logic set_v, clr_v;
        set_v = busy_set && (busy_addr != 5'd0);
        clr_v = we_b && (waddr_b != 5'd0) && mpend[waddr_b] && !(set_v && busy_addr == waddr_b);
        if (we_a && waddr_a != 5'd0 && mpend[waddr_a]) mwaw = 1'b1;
        if (we_a && waddr_a != 5'd0) mregs[waddr_a] = wdata_a;
        if (we_b && waddr_b != 5'd0) mregs[waddr_b] = wdata_b;
        if (clr_v) mpend[waddr_b] = 1'b0;
        if (set_v) mpend[busy_addr] = 1'b1;
    endtask

    task automatic push_comb();
        logic [4:0]  ra;
        logic [31:0] e;
        for (int p = 0; p < 2; p++) begin
            ra = raddr[p*5 +: 5];
            if (ra == 5'd0)                        e = 32'd0;
            else if (we_b && waddr_b == ra)        e = wdata_b;
            else if (we_a && waddr_a == ra)        e = wdata_a;
            else                                   e = mregs[ra];
            push($sformatf("rdata%0d_a%0d", p, ra), e);
            push($sformatf("rpend%0d_a%0d", p, ra),
                 32'(mpend[ra] && !(we_b && waddr_b == ra)));
        end
    endtask

    // One clock: comb outputs checked before the edge, registered outputs after it.
    task automatic cycle();
        push_comb();
        #1;
        chk(rdata[31:0]);
        chk(32'(rpend[0]));
        chk(rdata[63:32]);
        chk(32'(rpend[1]));
        @(posedge clk);
        if (!rst) model_update();
        push("pend_cnt", 32'(mcnt()));
        push("waw_err", 32'(mwaw));
        #1;
        chk(32'(pend_cnt));
        chk(32'(waw_err));
        @(negedge clk);
    endtask

    task automatic idle();
        we_a = 1'b0; waddr_a = 5'd0; wdata_a = 32'd0;
        we_b = 1'b0; waddr_b = 5'd0; wdata_b = 32'd0;
        busy_set = 1'b0; busy_addr = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        raddr = {5'd31, 5'd5};
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        push("r29_rdata0", 32'd5);  push("r29_rdata1", 32'd31);
        push("r29_rpend", 32'd0);   push("r29_cnt", 32'd0);
        #1;
        chk(rdata[31:0]); chk(rdata[63:32]); chk(32'(rpend)); chk(32'(pend_cnt));
        cycle();

        we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hDEAD; raddr = {5'd31, 5'd3};
        push("r30_bypass", 32'hDEAD); #1; chk(rdata[31:0]);
        cycle();
        idle();
        push("r30_stored", 32'hDEAD); #1; chk(rdata[31:0]);
        cycle();

        we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11;
        we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22; raddr = {5'd3, 5'd7};
        push("r31_bypass_b", 32'h22); #1; chk(rdata[31:0]);
        cycle();
        idle();
        push("r31_stored_b", 32'h22); #1; chk(rdata[31:0]);
        cycle();
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFF; raddr = {5'd7, 5'd0};
        push("r31_reg0_byp", 32'd0); #1; chk(rdata[31:0]);
        cycle();
        idle();
        push("r31_reg0", 32'd0); #1; chk(rdata[31:0]);
        cycle();

        busy_set = 1'b1; busy_addr = 5'd9; raddr = {5'd9, 5'd7};
        cycle();
        idle();
        push("r32_rpend1", 32'd1); push("r32_cnt1", 32'd1);
        #1; chk(32'(rpend[1])); chk(32'(pend_cnt));
        we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h55;
        push("r32_rpend1_clr", 32'd0); push("r32_rdata1", 32'h55);
        #1; chk(32'(rpend[1])); chk(rdata[63:32]);
        cycle();
        idle();
        push("r32_cnt0", 32'd0); #1; chk(32'(pend_cnt));

        busy_set = 1'b1; busy_addr = 5'd4; raddr = {5'd4, 5'd4};
        cycle();
        we_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'h44;
        cycle();
        idle();
        push("r33_cnt_keep", 32'd1); push("r33_rpend0", 32'd1);
        #1; chk(32'(pend_cnt)); chk(32'(rpend[0]));
        busy_set = 1'b1; busy_addr = 5'd4;
        cycle();
        idle();
        push("r33_cnt_repeat", 32'd1); #1; chk(32'(pend_cnt));
        we_a = 1'b1; waddr_a = 5'd4; wdata_a = 32'h77;
        cycle();
        idle();
        repeat (2) cycle();
        push("r33_waw_sticky", 32'd1); push("r33_rd4", 32'h77);
        #1; chk(32'(waw_err)); chk(rdata[31:0]);

        busy_set = 1'b1; busy_addr = 5'd10;
        cycle();
        busy_addr = 5'd11;
        cycle();
        idle();
        push("r34_cnt3", 32'd3); #1; chk(32'(pend_cnt));
        raddr = {5'd10, 5'd12};
        #1;
        rst = 1'b1;
        model_reset();
        push("r34_cnt_rst", 32'd0); push("r34_waw_rst", 32'd0);
        push("r34_reg12", 32'd12);  push("r34_reg10", 32'd10);
        #1;
        chk(32'(pend_cnt)); chk(32'(waw_err)); chk(rdata[31:0]); chk(rdata[63:32]);
        we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'hAA;
        busy_set = 1'b1; busy_addr = 5'd13;
        @(posedge clk);
        push("rst_ignore_cnt", 32'd0); #1; chk(32'(pend_cnt));
        @(negedge clk);
        idle();
        rst = 1'b0;
        push("rst_ignore_wr", 32'd12); #1; chk(rdata[31:0]);
        cycle();
        we_b = 1'b1; waddr_b = 5'd10; wdata_b = 32'h99;
        cycle();
        idle();
        push("r26_plain_wr", 32'h99); push("r26_cnt", 32'd0);
        #1; chk(rdata[63:32]); chk(32'(pend_cnt));

        repeat (60) begin
            we_a      = 1'($urandom_range(0, 1));
            waddr_a   = 5'($urandom_range(0, 7));
            wdata_a   = $urandom;
            we_b      = 1'($urandom_range(0, 1));
            waddr_b   = 5'($urandom_range(0, 7));
            wdata_b   = $urandom;
            busy_set  = 1'($urandom_range(0, 1));
            busy_addr = 5'($urandom_range(0, 7));
            raddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
REGFILE_MP_SB -- requirements
Module: regfile_mp_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port we_a/waddr_a/wdata_a, inputs, 1/ADDR_W/DATA_W, ALU writeback port.
REQ-007 The block SHALL have port we_b/waddr_b/wdata_b, inputs, 1/ADDR_W/DATA_W, multiplier writeback port.
REQ-008 The block SHALL have port raddr, input, NUM_RD*ADDR_W, packed read addresses; port i = slice i.
REQ-009 The block SHALL have port rdata, output, NUM_RD*DATA_W, packed read data.
REQ-010 The block SHALL have port rpend, output, NUM_RD, per-read-port "source pending" flag.
REQ-011 The block SHALL have port busy_set/busy_addr, inputs, 1/ADDR_W, multiplier issue: mark destination pending.
REQ-012 The block SHALL have port pend_cnt, output, ADDR_W+1, number of pending registers.
REQ-013 The block SHALL have port waw_err, output, 1, sticky error flag.

Function
REQ-014 Register 0 SHALL read as zero always; writes and busy_set to address 0 SHALL be ignored.
REQ-015 Writes SHALL take effect at the rising edge where the port enable is high; same edge both ports to same address: port B wins.
REQ-016 Reads SHALL be combinational, zero latency, with same-cycle bypass: if we_b and waddr_b==raddr_i (nonzero), rdata_i = wdata_b; else if we_a hit, rdata_i = wdata_a; else array value.
REQ-017 Scoreboard: one pending bit per register; busy_set sets bit busy_addr at next edge; we_b clears bit waddr_b at next edge.
REQ-018 Simultaneous busy_set and we_b clear on the same address SHALL leave the bit set (new issue wins).
REQ-019 rpend_i SHALL be pending[raddr_i] AND NOT (we_b and waddr_b==raddr_i); address 0 never pending.
REQ-020 pend_cnt SHALL be a registered count equal to the population of pending bits after each edge (+1 on new set, -1 on clear, net 0 when both hit different/already-set cases computed exactly); never wraps, range 0..2**ADDR_W-1.
REQ-021 busy_set to an already-pending address SHALL not change pend_cnt.
REQ-022 we_a to a register whose pending bit is set SHALL still write and SHALL set waw_err; waw_err stays high until rst.
REQ-023 we_b to a non-pending register SHALL write normally and not change the scoreboard or pend_cnt.

Reset
REQ-024 On rst assertion, register i SHALL take value i (zero-extended to DATA_W) immediately, asynchronously.
REQ-025 On rst, all pending bits, pend_cnt and waw_err SHALL clear to 0; writes and busy_set during rst SHALL be ignored.
REQ-026 Reset asserted mid-operation (pending multiply outstanding) SHALL discard the pending state; a later we_b to that address is a plain write.

Structure
REQ-027 Parameter defaults and the bypass-priority encoding SHALL live in shared package regfile_pkg.
REQ-028 Scoreboard (pending bits, pend_cnt, waw_err) SHALL be sub-module regfile_scoreboard; storage and bypass stay in the top.

Verification
REQ-029 Reset, read raddr={5,31} -> rdata={5,31}, rpend=0, pend_cnt=0.
REQ-030 we_a=1, waddr_a=3, wdata_a=0xDEAD, raddr0=3 same cycle -> rdata0=0xDEAD; next cycle array holds 0xDEAD.
REQ-031 we_a/we_b both to reg 7 with 0x11/0x22 -> bypass and stored value 0x22; write to reg 0 -> reads 0.
REQ-032 busy_set reg 9, raddr1=9 -> rpend1=1, pend_cnt=1; later we_b reg 9 data 0x55 -> same cycle rpend1=0, rdata1=0x55, then pend_cnt=0.
REQ-033 pending reg 4, same edge busy_set 4 and we_b 4 -> bit stays set, pend_cnt stays 1; we_a to 4 -> waw_err=1 until rst.
REQ-034 rst asserted between cycle edges with 3 pending -> immediate pend_cnt=0, reg i=i, waw_err=0.
